execute_muldiv: RTL and testbench

- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register (regE).
- Consumes the regE operand outputs and a mul/div opcode, then runs a radix-2 shift-add/shift-subtract FSM.
- Raises a stall request to ctrl so regE holds while the operation runs.
- Presents a one-cycle-valid 64-bit result that the execute result mux selects in place of the ALU output.

---
 rtl/execute_muldiv.sv | 199 +++++++++++++++++++
 tb/tb_execute_muldiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a 2-cycle fast path.
module execute_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regE_i_md_valid,
  input  logic [2:0]      regE_i_md_op,
  input  logic            regE_i_alu_W_instr,
  input  logic [XLEN-1:0] regE_i_valA,
  input  logic [XLEN-1:0] regE_i_valB,
  input  logic            ctrl_i_md_flush,
  output logic            execute_o_md_busy,
  output logic            execute_o_md_done,
  output logic [XLEN-1:0] execute_o_md_result
);

  localparam int unsigned DW = XLEN;
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [DW-1:0] b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic          w_q, w_d;
  logic          neg_q, neg_d;
  logic          neg_rem_q, neg_rem_d;
  logic [DW-1:0] result_q, result_d;

  logic          is_mul, is_sdiv, a_neg, b_neg;
  logic [DW-1:0] prep_a, prep_b, mag_a, mag_b, min_val, fast_res;
  logic          div_zero, div_ovf, mul_zero, fast;
  logic [DW:0]   mul_sum, div_diff;
  logic [PW-1:0] mul_next, div_next, acc_next, prod;
  logic [DW-1:0] quot, quot_s, rem_s, div_res, fin;

  // Operand preparation, sign handling and fast-path detection for a new op
  always_comb begin
    is_mul  = ~regE_i_md_op[2];
    is_sdiv = regE_i_md_op[2] & ~regE_i_md_op[0];
    prep_a  = regE_i_valA;
    prep_b  = regE_i_valB;
    if (regE_i_alu_W_instr) begin
      if (is_mul || is_sdiv) begin
        prep_a = {{HW{regE_i_valA[HW-1]}}, regE_i_valA[HW-1:0]};
        prep_b = {{HW{regE_i_valB[HW-1]}}, regE_i_valB[HW-1:0]};
      end else begin
        prep_a = {{HW{1'b0}}, regE_i_valA[HW-1:0]};
        prep_b = {{HW{1'b0}}, regE_i_valB[HW-1:0]};
      end
    end
    // MULH signs both operands, MULHSU only rs1; W multiplies only need the low half
    if (is_mul) begin
      a_neg = ~regE_i_alu_W_instr && (regE_i_md_op[1] ^ regE_i_md_op[0]) && prep_a[DW-1];
      b_neg = ~regE_i_alu_W_instr && (regE_i_md_op[1:0] == 2'd1) && prep_b[DW-1];
    end else begin
      a_neg = is_sdiv & prep_a[DW-1];
      b_neg = is_sdiv & prep_b[DW-1];
    end
    mag_a = a_neg ? -prep_a : prep_a;
    mag_b = b_neg ? -prep_b : prep_b;

    min_val  = regE_i_alu_W_instr ? {{HW{1'b1}}, 1'b1, {(HW-1){1'b0}}}
                                  : {1'b1, {(DW-1){1'b0}}};
    div_zero = ~is_mul && (prep_b == '0);
    div_ovf  = is_sdiv && (prep_a == min_val) && (prep_b == '1);
    mul_zero = is_mul && ((prep_a == '0) || (prep_b == '0));
    fast     = div_zero | div_ovf | mul_zero;

    fast_res = '0;
    if (div_zero) begin
      if (!regE_i_md_op[1])        fast_res = '1;
      else if (regE_i_alu_W_instr) fast_res = {{HW{prep_a[HW-1]}}, prep_a[HW-1:0]};
      else                         fast_res = prep_a;
    end else if (div_ovf) begin
      fast_res = regE_i_md_op[1] ? '0 : prep_a;
    end
  end

  // One iteration step and the final sign correction / result select
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:DW]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[DW-1:1]};
    // Top bit of acc joins the trial subtraction because 2*rem can exceed DW bits
    div_diff = acc_q[PW-1:DW-1] - {1'b0, b_q};
    div_next = div_diff[DW] ? {acc_q[PW-2:0], 1'b0}
                            : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
    acc_next = op_q[2] ? div_next : mul_next;

    prod    = neg_q ? -acc_next : acc_next;
    quot    = w_q ? {{HW{1'b0}}, acc_next[HW-1:0]} : acc_next[DW-1:0];
    quot_s  = neg_q ? -quot : quot;
    rem_s   = neg_rem_q ? -acc_next[PW-1:DW] : acc_next[PW-1:DW];
    div_res = op_q[1] ? rem_s : quot_s;

    if (!op_q[2]) begin
      if (w_q)                  fin = {{HW{acc_next[DW-1]}}, acc_next[DW-1:HW]};
      else if (op_q[1:0] == '0) fin = prod[DW-1:0];
      else                      fin = prod[PW-1:DW];
    end else begin
      fin = w_q ? {{HW{div_res[HW-1]}}, div_res[HW-1:0]} : div_res;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    op_d      = op_q;
    w_d       = w_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (regE_i_md_valid && !ctrl_i_md_flush) begin
          op_d      = regE_i_md_op;
          w_d       = regE_i_alu_W_instr;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = regE_i_alu_W_instr ? CW'(HW) : CW'(DW);
          if (!regE_i_alu_W_instr) begin
            acc_d = {{DW{1'b0}}, mag_a};
            b_d   = mag_b;
          end else if (is_mul) begin
            acc_d = {{(DW+HW){1'b0}}, mag_a[HW-1:0]};
            b_d   = {{HW{1'b0}}, mag_b[HW-1:0]};
          end else begin
            acc_d = {{DW{1'b0}}, mag_a[HW-1:0], {HW{1'b0}}};
            b_d   = mag_b;
          end
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (ctrl_i_md_flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = fin;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      op_q      <= '0;
      w_q       <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      op_q      <= op_d;
      w_q       <= w_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Busy is combinational so ctrl stalls regE in the cycle the op first appears
  assign execute_o_md_busy   = ((state_q == S_IDLE) && regE_i_md_valid && !ctrl_i_md_flush)
                               || (state_q == S_CALC);
  assign execute_o_md_done   = (state_q == S_DONE);
  assign execute_o_md_result = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Testbench for execute_muldiv: directed cases plus random ops against an arithmetic reference model.
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        md_valid;
  logic [2:0]  md_op;
  logic        w_i;
  logic [63:0] val_a, val_b;
  logic        flush;
  logic        busy, done;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_res;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  execute_muldiv dut (
    .clk                (clk),
    .rst                (rst),
    .regE_i_md_valid    (md_valid),
    .regE_i_md_op       (md_op),
    .regE_i_alu_W_instr (w_i),
    .regE_i_valA        (val_a),
    .regE_i_valB        (val_b),
    .ctrl_i_md_flush    (flush),
    .execute_o_md_busy  (busy),
    .execute_o_md_done  (done),
    .execute_o_md_result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of an RV64M op
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0]  a32, b32, r32;
    logic [127:0] pa, pb, p;
    logic [63:0]  r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (!op[2]) begin
        r32 = a32 * b32;
      end else if (!op[0]) begin
        if (b32 == 32'd0)                                    r32 = op[1] ? a32 : 32'hFFFF_FFFF;
        else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
        else if (op[1])                                      r32 = $signed(a32) % $signed(b32);
        else                                                 r32 = $signed(a32) / $signed(b32);
      end else begin
        if (b32 == 32'd0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
        else              r32 = op[1] ? (a32 % b32) : (a32 / b32);
      end
      return {{32{r32[31]}}, r32};
    end
    case (op)
      3'd0: r = a * b;
      3'd1, 3'd2, 3'd3: begin
        pa = (op != 3'd3) ? {{64{a[63]}}, a} : {64'd0, a};
        pb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = pa * pb;
        r  = p[127:64];
      end
      3'd4, 3'd6: begin
        if (b == 64'd0)                      r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (a == MIN64 && b == '1)      r = op[1] ? 64'd0 : a;
        else if (op[1])                      r = $signed(a) % $signed(b);
        else                                 r = $signed(a) / $signed(b);
      end
      default: begin
        if (b == 64'd0) r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else            r = op[1] ? (a % b) : (a / b);
      end
    endcase
    return r;
  endfunction

  // Cycles from the first IDLE cycle with valid to the done cycle
  function automatic int model_lat(input logic [2:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (!op[2]) begin
      if (w ? (a32 == 0 || b32 == 0) : (a == 0 || b == 0)) return 2;
      return w ? 34 : 66;
    end
    if (w) begin
      if (b32 == 0) return 2;
      if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 2;
      return 34;
    end
    if (b == 0) return 2;
    if (!op[0] && a == MIN64 && b == '1) return 2;
    return 66;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] exp;
    int lat, cyc, nb;
    exp = model(op, w, a, b);
    lat = model_lat(op, w, a, b);
    @(negedge clk);
    md_valid = 1'b1; md_op = op; w_i = w; val_a = a; val_b = b;
    #1;
    // Back-to-back: the previous op is still in DONE; the new one starts next cycle
    if (done) begin @(posedge clk); #1; end
    cyc = 1;
    nb  = busy ? 1 : 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (busy) nb++;
    end
    check({tag, ".res"},  result,     exp);
    check({tag, ".lat"},  64'(cyc),   64'(lat));
    check({tag, ".busy"}, 64'(nb),    64'(lat - 1));
    last_res = exp;
  endtask

  task automatic idle(input int n, output int pulses);
    @(negedge clk);
    md_valid = 1'b0;
    pulses = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
  endtask

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(1, 50));
      5: return {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int pulses, cyc;
    rst = 1'b0; md_valid = 1'b0; md_op = 3'd0; w_i = 1'b0;
    val_a = '0; val_b = '0; flush = 1'b0;
    #12;
    check("rst.busy",   64'(busy), 64'd0);
    check("rst.done",   64'(done), 64'd0);
    check("rst.result", result,    64'd0);
    @(negedge clk); rst = 1'b1;

    run_op("mul_7x-3",   3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    check("mul_7x-3.val", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
    idle(5, pulses);
    check("hold.result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    check("hold.pulses", 64'(pulses), 64'd0);
    run_op("mulhu_max",  3'd3, 1'b0, '1, '1);
    run_op("mulh_m1m1",  3'd1, 1'b0, '1, '1);
    run_op("div_-7_2",   3'd4, 1'b0, -64'sd7, 64'd2);
    run_op("rem_-7_2",   3'd6, 1'b0, -64'sd7, 64'd2);
    run_op("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7);
    run_op("remu_100_7", 3'd7, 1'b0, 64'd100, 64'd7);
    run_op("div_5_0",    3'd4, 1'b0, 64'd5, 64'd0);
    run_op("rem_5_0",    3'd6, 1'b0, 64'd5, 64'd0);
    run_op("div_ovf",    3'd4, 1'b0, MIN64, '1);
    run_op("rem_ovf",    3'd6, 1'b0, MIN64, '1);
    run_op("divuw",      3'd5, 1'b1, 64'h1234_5678_8000_0000, 64'd2);
    run_op("mulw",       3'd0, 1'b1, 64'h4000_0000, 64'd2);
    run_op("mulhw_asw",  3'd1, 1'b1, 64'hABCD_0000_4000_0003, 64'hFFFF_FFFF_FFFF_FFFB);
    run_op("remuw_0",    3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'hFFFF_0000_0000_0000);
    idle(1, pulses);

    // Flush in IDLE drops busy combinationally and starts nothing
    @(negedge clk); md_valid = 1'b1; md_op = 3'd5; val_a = 64'd1000; val_b = 64'd3; flush = 1'b1;
    #1; check("flush_idle.busy", 64'(busy), 64'd0);
    @(negedge clk); md_valid = 1'b0; flush = 1'b0;
    #1; check("flush_idle.busy2", 64'(busy), 64'd0);

    // Flush in CALC cycle 10
    @(negedge clk); md_valid = 1'b1; md_op = 3'd4; w_i = 1'b0;
    val_a = 64'h0123_4567_89AB_CDEF; val_b = 64'd77;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1; md_valid = 1'b0;
    #1; check("flush_calc.busy_now", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("flush_calc.busy_next", 64'(busy), 64'd0);
    @(negedge clk); flush = 1'b0;
    idle(80, pulses);
    check("flush_calc.pulses", 64'(pulses), 64'd0);
    run_op("divu_9_3", 3'd5, 1'b0, 64'd9, 64'd3);
    idle(1, pulses);

    // Reset mid-CALC
    @(negedge clk); md_valid = 1'b1; md_op = 3'd0; val_a = 64'd123456; val_b = 64'd789;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b0; md_valid = 1'b0;
    #1;
    check("rst_calc.busy",   64'(busy), 64'd0);
    check("rst_calc.done",   64'(done), 64'd0);
    check("rst_calc.result", result,    64'd0);
    @(negedge clk); rst = 1'b1;

    run_op("b2b_3x4", 3'd0, 1'b0, 64'd3, 64'd4);
    run_op("b2b_5x6", 3'd0, 1'b0, 64'd5, 64'd6);
    idle(80, pulses);
    check("b2b.extra_pulses", 64'(pulses), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic w;
      op = 3'($urandom_range(0, 7));
      w  = ($urandom_range(0, 3) == 0);
      run_op($sformatf("rnd%0d_op%0d_w%0d", i, op, w), op, w, rand_opnd(), rand_opnd());
      if ($urandom_range(0, 1) == 0) idle(1, pulses);
    end
    idle(3, pulses);
    check("final.pulses", 64'(pulses), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
